seq_delay_monitor: RTL and testbench

- Synthesizable RTL checker for the temporal property "a ##d b": when a is high, b must be high exactly d cycles later.
- The delay d is configurable at run time.
- Overlapping attempts are tracked in a pending shift register, one attempt per start cycle.
- Sits beside a DUT interface as an on-chip substitute for the simulation-only concurrent assertion.
- Exposes pass/fail pulses, saturating counters and first-failure capture for status registers.

---
 rtl/seq_delay_monitor.sv | 126 ++++++++++++
 tb/tb_seq_delay_monitor.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_delay_monitor.sv
// Synthesizable checker for "a ##d b" with a run-time delay, overlapping attempts,
// saturating pass/fail counters and capture of the first failing attempt's start cycle.
module seq_delay_monitor #(
    parameter int unsigned MAX_DELAY = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DW-1:0]    cfg_delay,
    input  logic             a,
    input  logic             b,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_valid,
    output logic [TS_W-1:0]  first_fail_start,
    output logic [TS_W-1:0]  cycle_cnt,
    output logic             busy
);

    localparam logic [DW-1:0]    MAX_D   = DW'(MAX_DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_DELAY-1:0] r_pending;
    logic [DW-1:0]        r_delay_q;
    logic                 r_pass_pulse;
    logic                 r_fail_pulse;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic                 r_ff_valid;
    logic [TS_W-1:0]      r_ff_start;
    logic [TS_W-1:0]      r_cycle_cnt;

    logic                 w_busy;
    logic [DW-1:0]        w_cfg_clamp;
    logic [DW-1:0]        w_de;
    logic                 w_start;
    logic                 w_pend_sel;
    logic [MAX_DELAY-1:0] w_pend_keep;
    logic [MAX_DELAY-1:0] w_pend_next;
    logic                 w_chk;
    logic                 w_chk_pass;
    logic                 w_chk_fail;
    logic [TS_W-1:0]      w_start_ts;

    // Delay is frozen while any attempt is outstanding.
    assign w_busy      = |r_pending;
    assign w_cfg_clamp = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;
    assign w_de        = w_busy ? r_delay_q : w_cfg_clamp;
    assign w_start     = en & a & (w_de != '0);

    // Select the attempt due this cycle and retire it so busy drops once all resolve.
    always_comb begin
        w_pend_sel  = 1'b0;
        w_pend_keep = r_pending;
        for (int unsigned k = 0; k < MAX_DELAY; k++) begin
            if (w_de == DW'(k + 1)) begin
                w_pend_sel     = r_pending[k];
                w_pend_keep[k] = 1'b0;
            end
        end
    end

    assign w_pend_next = MAX_DELAY'({w_pend_keep, w_start});
    assign w_chk       = en & ((w_de == '0) ? a : w_pend_sel);
    assign w_chk_pass  = w_chk & b;
    assign w_chk_fail  = w_chk & ~b;
    assign w_start_ts  = r_cycle_cnt - TS_W'(w_de);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_delay_q    <= '0;
            r_pass_pulse <= 1'b0;
            r_fail_pulse <= 1'b0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_start   <= '0;
            r_cycle_cnt  <= '0;
        end else begin
            r_delay_q    <= w_de;
            r_pending    <= en ? w_pend_next : '0;
            r_pass_pulse <= w_chk_pass;
            r_fail_pulse <= w_chk_fail;
            if (en) begin
                r_cycle_cnt <= r_cycle_cnt + TS_W'(1);
            end
            // clr outranks a same-edge result; the pulse above still fires.
            if (clr) begin
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_ff_valid <= 1'b0;
                r_ff_start <= '0;
            end else begin
                if (w_chk_pass && (r_pass_cnt != CNT_MAX)) begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end
                if (w_chk_fail) begin
                    if (r_fail_cnt != CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                    if (!r_ff_valid) begin
                        r_ff_valid <= 1'b1;
                        r_ff_start <= w_start_ts;
                    end
                end
            end
        end
    end

    assign pass_pulse       = r_pass_pulse;
    assign fail_pulse       = r_fail_pulse;
    assign pass_cnt         = r_pass_cnt;
    assign fail_cnt         = r_fail_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_start = r_ff_start;
    assign cycle_cnt        = r_cycle_cnt;
    assign busy             = w_busy;

endmodule

// File: tb/tb_seq_delay_monitor.sv
// Scoreboard bench for seq_delay_monitor: expected pulses are queued as the antecedent
// is driven and matched against the DUT pulses on each check cycle.
module tb_seq_delay_monitor;

    localparam int unsigned MAX_DELAY = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TS_W      = 32;
    localparam int unsigned DW        = $clog2(MAX_DELAY + 1);

    logic             clk = 1'b0;
    logic             rst, en, clr, a, b;
    logic [DW-1:0]    cfg_delay;
    logic             pass_pulse, fail_pulse, first_fail_valid, busy;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic [TS_W-1:0]  first_fail_start, cycle_cnt;

    logic             s_pass_pulse, s_fail_pulse, s_ffv, s_busy;
    logic [1:0]       s_pass_cnt, s_fail_cnt;
    logic [TS_W-1:0]  s_ffs, s_cycle_cnt;

    seq_delay_monitor #(.MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W), .TS_W(TS_W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_delay(cfg_delay), .a(a), .b(b),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_start(first_fail_start),
        .cycle_cnt(cycle_cnt), .busy(busy)
    );

    seq_delay_monitor #(.MAX_DELAY(MAX_DELAY), .CNT_W(2), .TS_W(TS_W)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_delay(cfg_delay), .a(a), .b(b),
        .pass_pulse(s_pass_pulse), .fail_pulse(s_fail_pulse),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
        .first_fail_valid(s_ffv), .first_fail_start(s_ffs),
        .cycle_cnt(s_cycle_cnt), .busy(s_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic pass;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; a = 1'b1; b = 1'b0; cfg_delay = '0;
        tick();
        tick();
        rst = 1'b0; a = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pass_pulse, fail_pulse, busy, first_fail_valid} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {pass_pulse, fail_pulse, busy, first_fail_valid});
        else passed++;
        checks++;
        if (pass_cnt !== '0 || fail_cnt !== '0)
            $display("FAIL reset_cnts got pass=%0d fail=%0d want 0/0", pass_cnt, fail_cnt);
        else passed++;
        checks++;
        if (cycle_cnt !== '0 || first_fail_start !== '0)
            $display("FAIL reset_ts got cyc=%0d ffs=%0d want 0/0", cycle_cnt, first_fail_start);
        else passed++;
    endtask

    task automatic test_basic_pass();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        d = 2; n = 6; va = 16'b000001; vb = 16'b000100;
        cfg_delay = DW'(d);
        for (int c = 0; c < n; c++) begin
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (pass_pulse !== ep || fail_pulse !== ef)
                $display("FAIL basic_pass_pulse cyc=%0d got p=%b f=%b want p=%b f=%b", c, pass_pulse, fail_pulse, ep, ef);
            else passed++;
        end
        checks++;
        if (pass_cnt !== CNT_W'(1) || fail_cnt !== CNT_W'(0) || sb.size() != 0)
            $display("FAIL basic_pass_cnt got pass=%0d fail=%0d left=%0d want 1/0/0", pass_cnt, fail_cnt, sb.size());
        else passed++;
    endtask

    task automatic test_basic_fail();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        d = 2; n = 5; va = 16'b00001; vb = 16'b00000;
        cfg_delay = DW'(d);
        for (int c = 0; c < n; c++) begin
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (pass_pulse !== ep || fail_pulse !== ef)
                $display("FAIL basic_fail_pulse cyc=%0d got p=%b f=%b want p=%b f=%b", c, pass_pulse, fail_pulse, ep, ef);
            else passed++;
        end
        checks++;
        if (fail_cnt !== CNT_W'(1) || pass_cnt !== CNT_W'(0))
            $display("FAIL basic_fail_cnt got pass=%0d fail=%0d want 0/1", pass_cnt, fail_cnt);
        else passed++;
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_start !== TS_W'(0))
            $display("FAIL basic_fail_capture got v=%b start=%0d want 1/0", first_fail_valid, first_fail_start);
        else passed++;
    endtask

    task automatic test_overlap();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        d = 2; n = 7; va = 16'b0000111; vb = 16'b0001100;
        cfg_delay = DW'(d);
        for (int c = 0; c < n; c++) begin
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (pass_pulse !== ep || fail_pulse !== ef)
                $display("FAIL overlap_pulse cyc=%0d got p=%b f=%b want p=%b f=%b", c, pass_pulse, fail_pulse, ep, ef);
            else passed++;
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0) $display("FAIL overlap_busy got %b want 0", busy);
                else passed++;
            end
        end
        checks++;
        if (pass_cnt !== CNT_W'(2) || fail_cnt !== CNT_W'(1) || first_fail_start !== TS_W'(2))
            $display("FAIL overlap_totals got pass=%0d fail=%0d ffs=%0d want 2/1/2", pass_cnt, fail_cnt, first_fail_start);
        else passed++;
    endtask

    task automatic test_zero_delay();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        d = 0; n = 8; va = 16'b01100000; vb = 16'b00100000;
        cfg_delay = DW'(d);
        for (int c = 0; c < n; c++) begin
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (pass_pulse !== ep || fail_pulse !== ef || busy !== 1'b0)
                $display("FAIL zero_delay_pulse cyc=%0d got p=%b f=%b busy=%b want p=%b f=%b busy=0", c, pass_pulse, fail_pulse, busy, ep, ef);
            else passed++;
        end
        checks++;
        if (pass_cnt !== CNT_W'(1) || fail_cnt !== CNT_W'(1) || first_fail_start !== TS_W'(6))
            $display("FAIL zero_delay_totals got pass=%0d fail=%0d ffs=%0d want 1/1/6", pass_cnt, fail_cnt, first_fail_start);
        else passed++;
    endtask

    task automatic test_clamp();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        n = 10; va = 16'b0000000001; vb = 16'b0100000000;
        cfg_delay = DW'(MAX_DELAY + 3);
        d = MAX_DELAY;
        for (int c = 0; c < n; c++) begin
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (pass_pulse !== ep || fail_pulse !== ef)
                $display("FAIL clamp_pulse cyc=%0d got p=%b f=%b want p=%b f=%b", c, pass_pulse, fail_pulse, ep, ef);
            else passed++;
        end
        checks++;
        if (pass_cnt !== CNT_W'(1) || fail_cnt !== CNT_W'(0) || busy !== 1'b0)
            $display("FAIL clamp_totals got pass=%0d fail=%0d busy=%b want 1/0/0", pass_cnt, fail_cnt, busy);
        else passed++;
    endtask

    task automatic test_config_lock();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        n = 8; va = 16'b00100001; vb = 16'b01001000;
        d = 3;
        cfg_delay = DW'(3);
        for (int c = 0; c < n; c++) begin
            if (c == 1) begin cfg_delay = DW'(1); end
            if (c == 4) d = 1;
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (pass_pulse !== ep || fail_pulse !== ef)
                $display("FAIL config_lock_pulse cyc=%0d got p=%b f=%b want p=%b f=%b", c, pass_pulse, fail_pulse, ep, ef);
            else passed++;
        end
        checks++;
        if (pass_cnt !== CNT_W'(2) || fail_cnt !== CNT_W'(0))
            $display("FAIL config_lock_totals got pass=%0d fail=%0d want 2/0", pass_cnt, fail_cnt);
        else passed++;
    endtask

    task automatic test_abort();
        do_reset();
        cfg_delay = DW'(2);
        b = 1'b1;
        for (int c = 0; c < 6; c++) begin
            a  = (c == 0);
            en = (c != 1);
            tick();
            checks++;
            if (pass_pulse !== 1'b0 || fail_pulse !== 1'b0)
                $display("FAIL abort_pulse cyc=%0d got p=%b f=%b want 0/0", c, pass_pulse, fail_pulse);
            else passed++;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b0 || cycle_cnt !== TS_W'(1))
                    $display("FAIL abort_state got busy=%b cyc=%0d want 0/1", busy, cycle_cnt);
                else passed++;
            end
        end
        en = 1'b1;
        checks++;
        if (pass_cnt !== '0 || fail_cnt !== '0 || cycle_cnt !== TS_W'(5))
            $display("FAIL abort_totals got pass=%0d fail=%0d cyc=%0d want 0/0/5", pass_cnt, fail_cnt, cycle_cnt);
        else passed++;
    endtask

    task automatic test_saturation_clr();
        logic [15:0] va, vb;
        int d, n;
        exp_t e;
        logic ep, ef;
        do_reset();
        d = 1; n = 7; va = 16'b0011111; vb = 16'b0000000;
        cfg_delay = DW'(d);
        for (int c = 0; c < n; c++) begin
            a = va[c]; b = vb[c];
            if (va[c] && (c + d < n)) begin e.cyc = c + d; e.pass = vb[c + d]; sb.push_back(e); end
            tick();
            ep = (sb.size() > 0) && (sb[0].cyc == c) && sb[0].pass;
            ef = (sb.size() > 0) && (sb[0].cyc == c) && !sb[0].pass;
            if (ep || ef) void'(sb.pop_front());
            checks++;
            if (s_pass_pulse !== ep || s_fail_pulse !== ef)
                $display("FAIL sat_pulse cyc=%0d got p=%b f=%b want p=%b f=%b", c, s_pass_pulse, s_fail_pulse, ep, ef);
            else passed++;
        end
        checks++;
        if (s_fail_cnt !== 2'd3 || fail_cnt !== CNT_W'(5))
            $display("FAIL sat_cnt got narrow=%0d wide=%0d want 3/5", s_fail_cnt, fail_cnt);
        else passed++;
        // clr with en low: counters and capture cleared, cycle index held
        en = 1'b0; clr = 1'b1; a = 1'b0;
        tick();
        clr = 1'b0;
        checks++;
        if (s_fail_cnt !== 2'd0 || fail_cnt !== '0 || first_fail_valid !== 1'b0 || first_fail_start !== '0)
            $display("FAIL clr_cnt got narrow=%0d wide=%0d v=%b ffs=%0d want 0/0/0/0", s_fail_cnt, fail_cnt, first_fail_valid, first_fail_start);
        else passed++;
        checks++;
        if (cycle_cnt !== TS_W'(7))
            $display("FAIL clr_cycle_cnt got %0d want 7", cycle_cnt);
        else passed++;
        // failing check on the same edge as clr: pulse fires, count and capture stay clear
        en = 1'b1; a = 1'b1; b = 1'b0;
        tick();
        a = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (fail_pulse !== 1'b1 || fail_cnt !== '0 || first_fail_valid !== 1'b0)
            $display("FAIL clr_wins got pulse=%b cnt=%0d v=%b want 1/0/0", fail_pulse, fail_cnt, first_fail_valid);
        else passed++;
        tick();
        checks++;
        if (fail_pulse !== 1'b0 || fail_cnt !== '0)
            $display("FAIL clr_after got pulse=%b cnt=%0d want 0/0", fail_pulse, fail_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_basic_fail();
        test_overlap();
        test_zero_delay();
        test_clamp();
        test_config_lock();
        test_abort();
        test_saturation_clr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
